// File: rtl/spike_rate_decoder_if.sv
// rtl/spike_rate_decoder_if.sv - control, spike input and result handshake bundle for spike_rate_decoder
interface spike_rate_decoder_if #(
    parameter int INT_WIDTH = 4
);
    logic                 en;
    logic                 start;
    logic                 spike_in;
    logic                 out_ready;
    logic [INT_WIDTH-1:0] value;
    logic                 out_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        output en, start, spike_in, out_ready,
        input  value, out_valid, busy, overrun
    );

    modport slave (
        input  en, start, spike_in, out_ready,
        output value, out_valid, busy, overrun
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - counts spikes over a WINDOW-cycle window and offers the saturated count on valid/ready
module spike_rate_decoder #(
    parameter int INT_WIDTH  = 4,
    parameter int WINDOW     = 15,
    parameter int CONTINUOUS = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spike_rate_decoder_if.slave   bus
);
    localparam int                   CW      = $clog2(WINDOW + 1);
    localparam logic [CW-1:0]        LAST    = CW'(WINDOW - 1);
    localparam logic [INT_WIDTH-1:0] ACC_MAX = '1;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [INT_WIDTH-1:0] acc_q, acc_d;
    logic [INT_WIDTH-1:0] value_q, value_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic [INT_WIDTH-1:0] acc_inc;

    // Accumulator pins at full scale instead of wrapping
    assign acc_inc = (bus.spike_in && (acc_q != ACC_MAX)) ? acc_q + INT_WIDTH'(1) : acc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        value_d   = value_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end

        // A completing window below overrides the consume above, so the new result wins
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = COUNT;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end
                end
                COUNT: begin
                    if (cnt_q == LAST) begin
                        value_d = acc_inc;
                        valid_d = 1'b1;
                        if (valid_q && !bus.out_ready) begin
                            overrun_d = 1'b1;
                        end
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = (CONTINUOUS != 0) ? COUNT : IDLE;
                    end else begin
                        acc_d = acc_inc;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.value     = value_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q == COUNT);
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - directed checks of spike_rate_decoder in one-shot, long-window and continuous builds
module tb_spike_rate_decoder;
    logic clk;
    logic rst_n;
    logic en_a, en_b, en_c;
    logic start, spike, out_ready;
    int   checks;
    int   errors;

    spike_rate_decoder_if #(.INT_WIDTH(4)) if_a ();
    spike_rate_decoder_if #(.INT_WIDTH(4)) if_b ();
    spike_rate_decoder_if #(.INT_WIDTH(4)) if_c ();

    assign if_a.en = en_a;
    assign if_a.start = start;
    assign if_a.spike_in = spike;
    assign if_a.out_ready = out_ready;
    assign if_b.en = en_b;
    assign if_b.start = start;
    assign if_b.spike_in = spike;
    assign if_b.out_ready = out_ready;
    assign if_c.en = en_c;
    assign if_c.start = start;
    assign if_c.spike_in = spike;
    assign if_c.out_ready = out_ready;

    spike_rate_decoder #(.INT_WIDTH(4), .WINDOW(15), .CONTINUOUS(0)) u_a (
        .clk_i(clk), .rst_i(rst_n), .bus(if_a.slave));
    spike_rate_decoder #(.INT_WIDTH(4), .WINDOW(20), .CONTINUOUS(0)) u_b (
        .clk_i(clk), .rst_i(rst_n), .bus(if_b.slave));
    spike_rate_decoder #(.INT_WIDTH(4), .WINDOW(10), .CONTINUOUS(1)) u_c (
        .clk_i(clk), .rst_i(rst_n), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // kind: 0 zeros, 1 ones, 2 alternating starting with 1
    task automatic feed(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            spike = (kind == 1) ? 1'b1 : (kind == 2) ? ((i % 2) == 0) : 1'b0;
            tick();
        end
        spike = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        start = 1'b0; spike = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_value", 32'(if_a.value), 32'd0);
        check("rst_valid", 32'(if_a.out_valid), 32'd0);
        check("rst_busy", 32'(if_a.busy), 32'd0);
        check("rst_overrun", 32'(if_a.overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        // all-ones window of 15
        en_a = 1'b1;
        send_start();
        check("t1_busy", 32'(if_a.busy), 32'd1);
        feed(14, 1);
        check("t1_valid_early", 32'(if_a.out_valid), 32'd0);
        spike = 1'b1;
        tick();
        spike = 1'b0;
        check("t1_value", 32'(if_a.value), 32'd15);
        check("t1_valid", 32'(if_a.out_valid), 32'd1);
        check("t1_busy_after", 32'(if_a.busy), 32'd0);
        consume();
        check("t1_consumed", 32'(if_a.out_valid), 32'd0);
        check("t1_value_hold", 32'(if_a.value), 32'd15);

        // alternating and silent windows
        send_start();
        feed(15, 2);
        check("t2_alt_value", 32'(if_a.value), 32'd8);
        consume();
        send_start();
        feed(15, 0);
        check("t2_zero_value", 32'(if_a.value), 32'd0);
        check("t2_zero_valid", 32'(if_a.out_valid), 32'd1);
        consume();
        en_a = 1'b0;

        // saturation with WINDOW=20
        en_b = 1'b1;
        send_start();
        feed(20, 1);
        check("t3_sat_value", 32'(if_b.value), 32'd15);
        check("t3_valid", 32'(if_b.out_valid), 32'd1);
        en_b = 1'b0;

        // continuous back-to-back windows with consumer stalled
        en_c = 1'b1;
        send_start();
        feed(3, 1);
        feed(7, 0);
        check("t4_w1_value", 32'(if_c.value), 32'd3);
        check("t4_w1_overrun", 32'(if_c.overrun), 32'd0);
        check("t4_w1_busy", 32'(if_c.busy), 32'd1);
        feed(7, 1);
        feed(3, 0);
        check("t4_w2_value", 32'(if_c.value), 32'd7);
        check("t4_w2_valid", 32'(if_c.out_valid), 32'd1);
        check("t4_overrun", 32'(if_c.overrun), 32'd1);
        en_c = 1'b0;
        tick();
        check("t4_stop_busy", 32'(if_c.busy), 32'd0);
        check("t4_stop_valid", 32'(if_c.out_valid), 32'd1);
        consume();
        check("t4_consumed", 32'(if_c.out_valid), 32'd0);
        check("t4_value_hold", 32'(if_c.value), 32'd7);
        check("t4_overrun_sticky", 32'(if_c.overrun), 32'd1);

        // asynchronous reset mid-window
        en_c = 1'b1;
        send_start();
        feed(5, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_value", 32'(if_c.value), 32'd0);
        check("t5_rst_valid", 32'(if_c.out_valid), 32'd0);
        check("t5_rst_busy", 32'(if_c.busy), 32'd0);
        check("t5_rst_overrun", 32'(if_c.overrun), 32'd0);
        rst_n = 1'b1;
        tick();
        send_start();
        feed(2, 1);
        feed(8, 0);
        check("t5_new_value", 32'(if_c.value), 32'd2);
        check("t5_new_valid", 32'(if_c.out_valid), 32'd1);
        en_c = 1'b0;
        tick();

        // en abort keeps prior result; start during COUNT ignored
        en_a = 1'b1;
        send_start();
        feed(6, 1);
        feed(9, 0);
        check("t6_prior_value", 32'(if_a.value), 32'd6);
        consume();
        send_start();
        feed(2, 1);
        start = 1'b1;
        spike = 1'b1;
        tick();
        start = 1'b0;
        feed(1, 1);
        en_a = 1'b0;
        tick();
        check("t6_abort_busy", 32'(if_a.busy), 32'd0);
        check("t6_abort_valid", 32'(if_a.out_valid), 32'd0);
        check("t6_abort_value", 32'(if_a.value), 32'd6);
        en_a = 1'b1;
        send_start();
        for (int i = 0; i < 15; i++) begin
            spike = 1'b1;
            start = (i == 4) || (i == 9);
            tick();
            if (i == 13) check("t6_len_early", 32'(if_a.out_valid), 32'd0);
        end
        start = 1'b0;
        spike = 1'b0;
        check("t6_len_valid", 32'(if_a.out_valid), 32'd1);
        check("t6_len_value", 32'(if_a.value), 32'd15);
        check("t6_len_busy", 32'(if_a.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
